// File: rtl/ibex_ex_imd_wb.sv
// ibex_ex_imd_wb
//
// Receiving end of the execute stage. The block holds the two 34-bit
// intermediate-value registers used by multi-cycle ALU/multdiv operations.
// It accepts completed EX results over a valid/ready handshake and buffers
// register-file writes in a small FIFO that drains to the RF write port.
// A combinational lookup forwards the youngest buffered write to a register.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   imd_val_we_i/_d_i/_q_o   intermediate value write enables, data, state
//   imd_clear_i              clear both intermediate registers
//   ex_valid_i/ex_ready_o    EX result handshake
//   ex_result_i, ex_rd_*     EX result data, destination and write enable
//   flush_i                  discard all buffered state
//   rf_we_o/rf_ready_i       RF write request (head valid) / RF accept
//   rf_waddr_o, rf_wdata_o   head entry, zero while empty
//   fwd_raddr_i              forwarding lookup address
//   fwd_hit_o, fwd_data_o    youngest-match forwarding result
module ibex_ex_imd_wb #(
    parameter int Depth    = 2,
    parameter int RegAddrW = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               imd_val_we_i,
    input  logic [1:0][33:0]         imd_val_d_i,
    output logic [1:0][33:0]         imd_val_q_o,
    input  logic                     imd_clear_i,
    input  logic                     ex_valid_i,
    output logic                     ex_ready_o,
    input  logic [31:0]              ex_result_i,
    input  logic [RegAddrW-1:0]      ex_rd_addr_i,
    input  logic                     ex_rd_we_i,
    input  logic                     flush_i,
    output logic                     rf_we_o,
    input  logic                     rf_ready_i,
    output logic [RegAddrW-1:0]      rf_waddr_o,
    output logic [31:0]              rf_wdata_o,
    input  logic [RegAddrW-1:0]      fwd_raddr_i,
    output logic                     fwd_hit_o,
    output logic [31:0]              fwd_data_o
);

    localparam int PtrW = (Depth > 2) ? 2 : 1;
    localparam int CntW = (Depth > 3) ? 3 : 2;

    // Pointers wrap modulo Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    logic [1:0][33:0]    imd_q, imd_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [RegAddrW-1:0] addr_q [Depth];
    logic [31:0]         data_q [Depth];

    logic push, pop;
    logic [PtrW-1:0] idx;

    // Ready never depends on rf_ready_i: a full FIFO frees a slot only
    // in the cycle after a pop.
    assign ex_ready_o = (count_q != CntW'(Depth)) && !flush_i;
    assign push       = ex_valid_i && ex_ready_o && ex_rd_we_i &&
                        (ex_rd_addr_i != '0);
    assign rf_we_o    = (count_q != '0);
    assign pop        = rf_we_o && rf_ready_i;

    assign rf_waddr_o  = rf_we_o ? addr_q[rd_ptr_q] : '0;
    assign rf_wdata_o  = rf_we_o ? data_q[rd_ptr_q] : '0;
    assign imd_val_q_o = imd_q;

    always_comb begin
        imd_d = imd_q;
        for (int i = 0; i < 2; i++) begin
            if (flush_i || imd_clear_i) begin
                imd_d[i] = '0;
            end else if (imd_val_we_i[i]) begin
                imd_d[i] = imd_val_d_i[i];
            end
        end
    end

    // A pop in the flush cycle still happens (the RF took it), but the
    // whole FIFO is emptied anyway, so flush simply zeroes the state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            imd_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            imd_q    <= imd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_ptr_q] <= ex_rd_addr_i;
            data_q[wr_ptr_q] <= ex_result_i;
        end
    end

    // Walk valid entries oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        idx        = rd_ptr_q;
        for (int i = 0; i < Depth; i++) begin
            if ((CntW'(i) < count_q) && (fwd_raddr_i != '0) &&
                (addr_q[idx] == fwd_raddr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_q[idx];
            end
            idx = ptr_inc(idx);
        end
    end

endmodule
